// File: rtl/memory_responder_32.sv
// Word-addressed synchronous RAM responder for the CPU memory port.
// A request (read or write strobe) is accepted in IDLE, stalls for WAIT_STATES
// cycles, then completes with a one-cycle ready pulse and an error flag.
//
// Ports:
//   clk         - clock, all state changes on the rising edge
//   in_clear_n  - synchronous active-low reset
//   in_addr     - word address (MAR)
//   in_wdata    - write data (MDR)
//   in_read     - read request level, sampled in IDLE only
//   in_write    - write request level, sampled in IDLE only
//   out_rdata   - registered read data, held between reads
//   out_ready   - one-cycle completion pulse
//   out_busy    - high while a request is in WAIT or RESP
//   out_error   - qualified by out_ready; 1 = request rejected, held until next completion
module memory_responder_32 #(
  parameter int unsigned ADDR_BITS   = 9,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        in_clear_n,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic        in_read,
  input  logic        in_write,
  output logic [31:0] out_rdata,
  output logic        out_ready,
  output logic        out_busy,
  output logic        out_error
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [31:0]        r_addr;
  logic [31:0]        w_addr_nxt;
  logic [31:0]        r_wdata;
  logic [31:0]        w_wdata_nxt;
  logic               r_op_rd;
  logic               w_op_rd_nxt;
  logic               r_op_wr;
  logic               w_op_wr_nxt;
  logic [31:0]        r_rdata;
  logic [31:0]        w_rdata_nxt;
  logic               r_ready;
  logic               w_ready_nxt;
  logic               r_busy;
  logic               w_busy_nxt;
  logic               r_error;
  logic               w_error_nxt;
  logic               w_mem_we;
  logic               w_in_range;
  logic [ADDR_BITS-1:0] w_mem_idx;

  logic [31:0] r_mem [DEPTH];

  // Out-of-range addresses are rejected rather than aliased onto the array.
  assign w_mem_idx  = r_addr[ADDR_BITS-1:0];
  assign w_in_range = (r_addr[31:ADDR_BITS] == '0);

  // State register
  always_ff @(posedge clk) begin
    if (!in_clear_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-register values
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_op_rd_nxt = r_op_rd;
    w_op_wr_nxt = r_op_wr;
    w_rdata_nxt = r_rdata;
    w_ready_nxt = 1'b0;
    w_busy_nxt  = r_busy;
    w_error_nxt = r_error;
    w_mem_we    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (in_read || in_write) begin
          w_addr_nxt  = in_addr;
          w_wdata_nxt = in_wdata;
          w_op_rd_nxt = in_read;
          w_op_wr_nxt = in_write;
          w_cnt_nxt   = CNT_W'(WAIT_STATES);
          w_busy_nxt  = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_ready_nxt = 1'b1;
          w_state_nxt = ST_RESP;
          if (r_op_rd && r_op_wr) begin
            // Conflicting strobes: reject, leave read data untouched.
            w_error_nxt = 1'b1;
          end else if (!w_in_range) begin
            w_error_nxt = 1'b1;
            if (r_op_rd) begin
              w_rdata_nxt = '0;
            end
          end else begin
            w_error_nxt = 1'b0;
            if (r_op_rd) begin
              w_rdata_nxt = r_mem[w_mem_idx];
            end else begin
              w_mem_we = 1'b1;
            end
          end
        end
      end
      ST_RESP: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!in_clear_n) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_op_rd <= 1'b0;
      r_op_wr <= 1'b0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_op_rd <= w_op_rd_nxt;
      r_op_wr <= w_op_wr_nxt;
      r_rdata <= w_rdata_nxt;
      r_ready <= w_ready_nxt;
      r_busy  <= w_busy_nxt;
      r_error <= w_error_nxt;
    end
  end

  // Storage array; never cleared, and a reset edge suppresses a pending write.
  always_ff @(posedge clk) begin
    if (in_clear_n && w_mem_we) begin
      r_mem[w_mem_idx] <= r_wdata;
    end
  end

  assign out_rdata = r_rdata;
  assign out_ready = r_ready;
  assign out_busy  = r_busy;
  assign out_error = r_error;

endmodule

// File: tb/tb_memory_responder_32.sv
module tb_memory_responder_32;

  localparam int unsigned WS = 1;

  logic        clk;
  logic        in_clear_n;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        in_read;
  logic        in_write;
  logic [31:0] out_rdata;
  logic        out_ready;
  logic        out_busy;
  logic        out_error;

  typedef struct packed {
    int unsigned cyc;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  memory_responder_32 #(.ADDR_BITS(9), .WAIT_STATES(WS)) dut (
    .clk        (clk),
    .in_clear_n (in_clear_n),
    .in_addr    (in_addr),
    .in_wdata   (in_wdata),
    .in_read    (in_read),
    .in_write   (in_write),
    .out_rdata  (out_rdata),
    .out_ready  (out_ready),
    .out_busy   (out_busy),
    .out_error  (out_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ready pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("ready_cycle", cyc, e.cyc);
        check("ready_error", 32'(out_error), 32'(e.err));
        check("ready_rdata", out_rdata, e.rdata);
      end
    end
  end

  // Issue one request, push its expected completion, return once IDLE again.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd,
                        input logic exp_err);
    exp_t e;
    in_read  = rd;
    in_write = wr;
    in_addr  = addr;
    in_wdata = wdata;
    e.cyc   = cyc + 1 + 1 + WS;
    e.rdata = exp_rd;
    e.err   = exp_err;
    sb_q.push_back(e);
    @(posedge clk); #1;
    in_read  = 1'b0;
    in_write = 1'b0;
    in_addr  = 32'hFFFF_FFFF;
    in_wdata = 32'h5555_5555;
    repeat (WS + 2) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    in_clear_n = 1'b0;
    in_read    = 1'b1;
    in_write   = 1'b1;
    in_addr    = 32'd5;
    in_wdata   = 32'h1;

    // Reset held two cycles with strobes asserted
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("rst_rdata", out_rdata, 32'd0);
      check("rst_ready", 32'(out_ready), 32'd0);
      check("rst_busy", 32'(out_busy), 32'd0);
      check("rst_error", 32'(out_error), 32'd0);
    end
    in_read    = 1'b0;
    in_write   = 1'b0;
    in_clear_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_busy", 32'(out_busy), 32'd0);

    // Write then read, one wait state
    do_req(1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF, 32'd0, 1'b0);
    do_req(1'b1, 1'b0, 32'd5, 32'h0, 32'hDEAD_BEEF, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rdata_held", out_rdata, 32'hDEAD_BEEF);

    // Held read level: two accepts, WS+3 apart
    do_req(1'b0, 1'b1, 32'd7, 32'h0000_0042, 32'hDEAD_BEEF, 1'b0);
    begin
      exp_t e;
      int unsigned k;
      k = cyc + 1;
      e.rdata = 32'h0000_0042;
      e.err   = 1'b0;
      e.cyc   = k + 2;
      sb_q.push_back(e);
      e.cyc   = k + 6;
      sb_q.push_back(e);
      in_addr = 32'd7;
      in_read = 1'b1;
      for (int j = 0; j < 7; j++) begin
        @(posedge clk); #1;
        check("held_busy", 32'(out_busy), (j == 3) ? 32'd0 : 32'd1);
        if (j == 6) in_read = 1'b0;
      end
      @(posedge clk); #1;
    end

    // Out-of-range write is dropped, must not alias onto addr 0
    do_req(1'b0, 1'b1, 32'd0, 32'h1111_1111, 32'h0000_0042, 1'b0);
    do_req(1'b0, 1'b1, 32'h200, 32'h0000_1234, 32'h0000_0042, 1'b1);
    check("error_held", 32'(out_error), 32'd1);
    do_req(1'b1, 1'b0, 32'd0, 32'h0, 32'h1111_1111, 1'b0);
    do_req(1'b1, 1'b0, 32'h200, 32'h0, 32'h0, 1'b1);

    // Conflicting strobes
    do_req(1'b0, 1'b1, 32'd3, 32'hA5A5_A5A5, 32'h0, 1'b0);
    do_req(1'b1, 1'b1, 32'd3, 32'h0, 32'h0, 1'b1);
    do_req(1'b1, 1'b0, 32'd3, 32'h0, 32'hA5A5_A5A5, 1'b0);

    // Reset during WAIT abandons the write
    do_req(1'b0, 1'b1, 32'd9, 32'h0BAD_C0DE, 32'hA5A5_A5A5, 1'b0);
    in_write = 1'b1;
    in_addr  = 32'd9;
    in_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    in_write   = 1'b0;
    in_clear_n = 1'b0;
    @(posedge clk); #1;
    in_clear_n = 1'b1;
    check("abort_rdata", out_rdata, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("abort_busy", 32'(out_busy), 32'd0);
    end
    do_req(1'b1, 1'b0, 32'd9, 32'h0, 32'h0BAD_C0DE, 1'b0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
    #1;
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
